// File: rtl/instr_fetch_unit.sv
// Instruction fetch for a single-cycle RISC-V core: PC, word-addressed program memory,
// field decode, and IDLE/RUN/HALT run control with fault detection and a retire counter.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          PCSrc,
    input  logic [XLEN-1:0]               pc_target,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               pc_plus4,
    output logic [31:0]                   instr,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic                          funct7_5,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic                          instr_valid,
    output logic                          halted,
    output logic                          fault,
    output logic [31:0]                   retired
);

    localparam int unsigned     AddrW   = $clog2(IMEM_DEPTH);
    localparam logic [31:0]     Nop     = 32'h0000_0013;
    localparam logic [31:0]     Ebreak  = 32'h0010_0073;
    localparam logic [XLEN-1:0] PcLimit = XLEN'(IMEM_DEPTH) << 2;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     retired_q, retired_d;
    logic            fault_q, fault_d;
    logic            halted_q, halted_d;
    logic            valid_q, valid_d;
    logic [31:0]     mem_q [IMEM_DEPTH];
    logic [XLEN-1:0] next_pc;
    logic            next_bad;

    // Program memory has no reset; a write is dropped while reset is held.
    always_ff @(posedge clk) begin
        if (load_en && rst_n && (state_q == StIdle)) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign instr    = (state_q == StRun) ? mem_q[pc_q[AddrW+1:2]] : Nop;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];

    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

    assign next_pc  = PCSrc ? pc_target : pc_plus4;
    assign next_bad = (next_pc[1:0] != 2'b00) || (next_pc >= PcLimit);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        halted_d  = halted_q;
        valid_d   = valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    valid_d   = 1'b1;
                    halted_d  = 1'b0;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (instr == Ebreak) begin
                        state_d   = StHalt;
                        retired_d = retired_q + 32'd1;
                        valid_d   = 1'b0;
                        halted_d  = 1'b1;
                    end else if (next_bad) begin
                        // Faulting fetch does not retire; PC stays on the offending instruction.
                        state_d  = StHalt;
                        fault_d  = 1'b1;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_q + 32'd1;
                    end
                end
            end
            StHalt: begin
                if (start) begin
                    state_d  = StIdle;
                    pc_d     = RESET_PC;
                    fault_d  = 1'b0;
                    halted_d = 1'b0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                state_d  = StIdle;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            fault_q   <= 1'b0;
            halted_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            halted_q  <= halted_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences and random stimulus
// checked against a behavioural model of the run-control rules.
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int          SIDLE  = 0;
    localparam int          SRUN   = 1;
    localparam int          SHALT  = 2;

    logic        clk, rst_n;
    logic        ld_en, start, stall, pcsrc;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data, tgt;
    logic [31:0] pc, pc_plus4, instr, retired;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5, instr_valid, halted, fault;
    logic [4:0]  rd, rs1, rs2;

    instr_fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (ld_en),
        .load_addr   (ld_addr),
        .load_data   (ld_data),
        .start       (start),
        .stall       (stall),
        .PCSrc       (pcsrc),
        .pc_target   (tgt),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_state;
    logic [31:0] m_pc, m_retired;
    logic        m_fault;
    logic [31:0] m_mem [DEPTH];

    typedef struct {
        logic        ld;
        logic [5:0]  la;
        logic [31:0] ldat;
        logic        st, stl, src;
        logic [31:0] tg;
        logic [31:0] e_pc, e_ret;
        logic        e_v, e_h, e_f;
        logic [6:0]  e_op;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mkv(logic ld, logic [5:0] la, logic [31:0] ldat, logic st,
                                 logic stl, logic src, logic [31:0] tg, logic [31:0] e_pc,
                                 logic [31:0] e_ret, logic e_v, logic e_h, logic e_f,
                                 logic [6:0] e_op);
        vec_t v;
        v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.stl = stl; v.src = src; v.tg = tg;
        v.e_pc = e_pc; v.e_ret = e_ret; v.e_v = e_v; v.e_h = e_h; v.e_f = e_f; v.e_op = e_op;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = SIDLE;
        m_pc      = 32'h0;
        m_retired = 32'h0;
        m_fault   = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] cur, nxt;
        if (m_state == SIDLE) begin
            if (ld_en) m_mem[ld_addr] = ld_data;
            if (start) begin
                m_state   = SRUN;
                m_pc      = 32'h0;
                m_retired = 32'h0;
            end
        end else if (m_state == SRUN) begin
            if (!stall) begin
                cur = m_mem[m_pc / 4];
                if (cur == EBREAK) begin
                    m_state   = SHALT;
                    m_retired = m_retired + 1;
                end else begin
                    nxt = pcsrc ? tgt : m_pc + 4;
                    if ((nxt % 4) != 0 || nxt >= 4 * DEPTH) begin
                        m_fault = 1'b1;
                        m_state = SHALT;
                    end else begin
                        m_pc      = nxt;
                        m_retired = m_retired + 1;
                    end
                end
            end
        end else if (start) begin
            m_state = SIDLE;
            m_fault = 1'b0;
            m_pc    = 32'h0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ei;
        ei = (m_state == SRUN) ? m_mem[m_pc / 4] : NOP;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 4);
        check({tag, ".instr"}, instr, ei);
        check({tag, ".opcode"}, {25'b0, opcode}, {25'b0, ei[6:0]});
        check({tag, ".funct3"}, {29'b0, funct3}, {29'b0, ei[14:12]});
        check({tag, ".f7_5"}, {31'b0, funct7_5}, {31'b0, ei[30]});
        check({tag, ".rd"}, {27'b0, rd}, {27'b0, ei[11:7]});
        check({tag, ".rs1"}, {27'b0, rs1}, {27'b0, ei[19:15]});
        check({tag, ".rs2"}, {27'b0, rs2}, {27'b0, ei[24:20]});
        check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, m_state == SRUN});
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_state == SHALT});
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
        check({tag, ".retired"}, retired, m_retired);
    endtask

    // Inputs are stable here; advance the model, take one edge, sample 1ns later.
    task automatic cycle(input bit chk, input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (chk) check_all(tag);
    endtask

    task automatic idle_inputs();
        ld_en = 0; ld_addr = '0; ld_data = '0; start = 0; stall = 0; pcsrc = 0; tgt = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all("in_rst");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");

        // Fill the whole memory so no fetch ever reads an unwritten word.
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1; ld_addr = 6'(i); ld_data = $urandom;
            if (ld_data == EBREAK) ld_data = NOP;
            cycle(1, "fill");
        end
        idle_inputs();

        tbl[0]  = mkv(1, 0, 32'h0010_0293, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 7'h13);
        tbl[1]  = mkv(1, 1, 32'h0073_02B3, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 7'h13);
        tbl[2]  = mkv(1, 2, 32'h0010_0073, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 7'h13);
        tbl[3]  = mkv(1, 4, 32'h40B5_0533, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 7'h13);
        tbl[4]  = mkv(1, 3, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 7'h13);
        tbl[5]  = mkv(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 7'h13);
        tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 0, 0, 7'h33);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 32'h8, 2, 1, 0, 0, 7'h73);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 32'h8, 3, 0, 1, 0, 7'h13);
        tbl[9]  = mkv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h8, 3, 0, 1, 0, 7'h13);
        tbl[10] = mkv(0, 0, 0, 1, 0, 0, 0, 32'h0, 3, 0, 0, 0, 7'h13);
        tbl[11] = mkv(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 7'h13);
        tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 0, 0, 7'h33);
        tbl[13] = mkv(0, 0, 0, 0, 0, 1, 32'h10, 32'h10, 2, 1, 0, 0, 7'h33);
        tbl[14] = mkv(0, 0, 0, 0, 0, 1, 32'h12, 32'h10, 2, 0, 1, 1, 7'h13);
        tbl[15] = mkv(0, 0, 0, 1, 0, 0, 0, 32'h0, 2, 0, 0, 0, 7'h13);
        tbl[16] = mkv(1, 2, 32'h0020_8133, 0, 0, 0, 0, 32'h0, 2, 0, 0, 0, 7'h13);
        tbl[17] = mkv(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 7'h13);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 1, 0, 0, 7'h33);
        tbl[19] = mkv(0, 0, 0, 0, 0, 0, 0, 32'h8, 2, 1, 0, 0, 7'h33);
        tbl[20] = mkv(1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h8, 2, 1, 0, 0, 7'h33);
        tbl[21] = mkv(0, 0, 0, 0, 1, 0, 0, 32'h8, 2, 1, 0, 0, 7'h33);
        tbl[22] = mkv(0, 0, 0, 0, 1, 0, 0, 32'h8, 2, 1, 0, 0, 7'h33);
        tbl[23] = mkv(0, 0, 0, 0, 0, 0, 0, 32'hC, 3, 1, 0, 0, 7'h13);
        tbl[24] = mkv(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4, 1, 0, 0, 7'h13);

        for (int i = 0; i < 25; i++) begin
            ld_en = tbl[i].ld; ld_addr = tbl[i].la; ld_data = tbl[i].ldat;
            start = tbl[i].st; stall = tbl[i].stl; pcsrc = tbl[i].src; tgt = tbl[i].tg;
            cycle(0, "tbl");
            check($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
            check($sformatf("tbl%0d.retired", i), retired, tbl[i].e_ret);
            check($sformatf("tbl%0d.valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_v});
            check($sformatf("tbl%0d.halted", i), {31'b0, halted}, {31'b0, tbl[i].e_h});
            check($sformatf("tbl%0d.fault", i), {31'b0, fault}, {31'b0, tbl[i].e_f});
            check($sformatf("tbl%0d.opcode", i), {25'b0, opcode}, {25'b0, tbl[i].e_op});
        end
        idle_inputs();

        // Reset in the middle of RUN takes effect without waiting for a clock edge.
        cycle(1, "pre_rst");
        cycle(1, "pre_rst");
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst.pc", pc, 32'h0);
        check("midrst.retired", retired, 32'h0);
        check("midrst.instr", instr, NOP);
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_midrst");

        // Straight-line fetch runs off the end of memory.
        start = 1;
        cycle(1, "seq_start");
        start = 0;
        for (int n = 0; n < 100 && !halted; n++) cycle(1, "seq");
        check("seq.halted", {31'b0, halted}, 32'h1);
        check("seq.fault", {31'b0, fault}, 32'h1);
        check("seq.pc", pc, 32'd252);
        check("seq.retired", retired, 32'd63);

        start = 1;
        cycle(1, "halt2idle");
        check("h2i.fault", {31'b0, fault}, 32'h0);
        check("h2i.retired_held", retired, 32'd63);
        cycle(1, "idle2run");
        check("i2r.retired", retired, 32'h0);
        check("i2r.pc", pc, 32'h0);
        start = 0;

        for (int n = 0; n < 1500; n++) begin
            ld_en   = ($urandom_range(0, 7) == 0);
            ld_addr = 6'($urandom_range(0, DEPTH - 1));
            ld_data = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
            start   = ($urandom_range(0, 9) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            pcsrc   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom;
                1:       tgt = $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
                default: tgt = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            cycle(1, "rnd");
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the instruction side of the single-cycle RISC-V datapath: holds the PC, stores the program in a word-addressed instruction memory, and presents the decoded fields (opcode, funct3, funct7_5, register indices) that the control unit consumes.
- Consumes the control unit's PCSrc decision and the datapath's branch/jump target, and steers the next PC from them.
- Adds run control (IDLE/RUN/HALT), program loading, stall, EBREAK halt, fault detection and a retired-instruction counter.

Parameters:
XLEN, 32, PC and data width.
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; power of two.
RESET_PC, 32'h0000_0000, PC value after reset and on start.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
load_en  input  1  write one program word; honoured only in IDLE.
load_addr  input  log2(IMEM_DEPTH)  word index for load.
load_data  input  32  instruction word to load.
start  input  1  IDLE->RUN pulse.
stall  input  1  hold PC and counter this cycle (RUN only).
PCSrc  input  1  from control unit; 1 = take pc_target.
pc_target  input  XLEN  branch/jump target from datapath.
pc  output  XLEN  current PC.
pc_plus4  output  XLEN  pc + 4, wraps modulo 2^XLEN.
instr  output  32  instruction at pc; 32'h0000_0013 (NOP) when not RUN.
opcode  output  7  instr[6:0].
funct3  output  3  instr[14:12].
funct7_5  output  1  instr[30].
rd, rs1, rs2  output  5 each  instr[11:7], [19:15], [24:20].
instr_valid  output  1  high only in RUN.
halted  output  1  high in HALT.
fault  output  1  sticky; set on misaligned or out-of-range fetch.
retired  output  32  count of instructions that advanced the PC.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, retired=0, fault=0, halted=0, instr_valid=0, instr=NOP. Memory contents are not cleared.
- Memory: asynchronous (combinational) read at index pc[log2(IMEM_DEPTH)+1:2]; synchronous write on clk when load_en and state==IDLE. load_en in RUN/HALT is ignored.
- Field outputs are always sliced from the instr output, so in IDLE/HALT they decode the NOP.
- IDLE: start=1 -> RUN next cycle, pc=RESET_PC. If start and load_en occur together, the load completes and the state still goes to RUN.
- RUN, stall=1: pc, retired and state hold. instr_valid stays 1.
- RUN, stall=0, per edge, evaluated in priority order:
  1. instr==32'h0010_0073 (EBREAK): go to HALT; pc unchanged; retired+1.
  2. next=(PCSrc ? pc_target : pc_plus4). If next[1:0]!=0 or next>=4*IMEM_DEPTH: fault<=1, HALT, pc unchanged, retired unchanged.
  3. Otherwise pc<=next, retired+1.
- pc_target is examined only when PCSrc=1.
- HALT: all state held; instr_valid=0; halted=1. start=1 -> IDLE (fault cleared, pc=RESET_PC, retired held until the next RUN entry, where it is cleared to 0). Only rst_n or start leaves HALT.
- retired wraps modulo 2^32.
- Reset asserted mid-RUN aborts immediately; no partial PC update.
- An asynchronous reset does not corrupt an in-progress load; the write simply does not occur while rst_n=0.

Test Plan:
- Load words 0..2 = addi, add (32'h0073_02B3), EBREAK; pulse start; PCSrc=0 -> pc steps 0,4,8; opcode=7'b0110011 at pc=4; HALT at pc=8, retired=3, instr_valid=0.
- RUN at pc=4 with PCSrc=1, pc_target=32'h10 -> next pc=32'h10; PCSrc=1, pc_target=32'h12 -> fault=1, halted=1, pc stays 32'h10.
- stall=1 for 3 cycles at pc=8 -> pc=8, retired unchanged; release -> pc=12.
- Sequential fetch with IMEM_DEPTH=64 reaching pc=252 without a branch -> next=256 is out of range -> fault=1, HALT, pc=252.
- load_en during RUN with load_addr=0, data=0xFFFFFFFF -> word 0 unchanged after return to IDLE; rst_n low mid-RUN -> pc=0, retired=0, instr=NOP in the same cycle.
- HALT then start -> IDLE, fault=0; start again -> RUN from RESET_PC with retired=0.
